// File: rtl/video_out_gen.sv
// Camera-style pixel transmitter: pops packed 4-pixel words from a FWFT FIFO and
// replays them with programmable active/blanking timing plus frame_valid/line_valid framing.
module video_out_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        enable,
    input  logic [31:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_r_ack,
    output logic        frame_valid,
    output logic        line_valid,
    output logic [7:0]  pixel_out,
    output logic        underrun,
    output logic        frame_done
);

    localparam int H_TOT = H_ACTIVE + H_BLANK;
    localparam int V_TOT = V_ACTIVE + V_BLANK;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_LPIX_C = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_LLIN_C = VW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    // Only the three not-yet-emitted pixels of the current word need storing.
    logic [23:0]   shreg_q, shreg_d;
    logic          underrun_q, underrun_d;
    logic          fv_q, fv_d;
    logic          lv_q, lv_d;
    logic [7:0]    pix_q, pix_d;
    logic          fd_q, fd_d;

    logic run, act_v, act, grp, pop, h_wrap, v_wrap;

    always_comb begin
        run    = (state_q == RUN);
        act_v  = run && (v_q < V_ACT_C);
        act    = act_v && (h_q < H_ACT_C);
        grp    = act && (h_q[1:0] == 2'b00);
        pop    = grp && !fifo_empty;
        h_wrap = (h_q == H_LAST_C);
        v_wrap = (v_q == V_LAST_C);
    end

    assign fifo_r_ack = pop;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                h_d = '0;
                v_d = '0;
                if (enable) state_d = FILL;
            end
            FILL: begin
                h_d = '0;
                v_d = '0;
                if (!fifo_empty) state_d = RUN;
            end
            RUN: begin
                if (h_wrap) begin
                    h_d = '0;
                    // enable is only sampled at the frame boundary so frames never truncate.
                    if (v_wrap) begin
                        v_d = '0;
                        if (!enable) state_d = IDLE;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    always_comb begin
        shreg_d    = shreg_q;
        underrun_d = underrun_q;
        if (pop) begin
            shreg_d = fifo_data[23:0];
        end else if (grp) begin
            // Missing word: keep line timing, emit four zero pixels.
            shreg_d    = '0;
            underrun_d = 1'b1;
        end else if (act) begin
            shreg_d = {shreg_q[15:0], 8'h00};
        end

        fv_d  = act_v;
        lv_d  = act;
        pix_d = 8'h00;
        if (grp) begin
            if (pop) pix_d = fifo_data[31:24];
        end else if (act) begin
            pix_d = shreg_q[23:16];
        end
        fd_d = act && (v_q == V_LLIN_C) && (h_q == H_LPIX_C);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            h_q        <= '0;
            v_q        <= '0;
            shreg_q    <= '0;
            underrun_q <= 1'b0;
            fv_q       <= 1'b0;
            lv_q       <= 1'b0;
            pix_q      <= 8'h00;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            v_q        <= v_d;
            shreg_q    <= shreg_d;
            underrun_q <= underrun_d;
            fv_q       <= fv_d;
            lv_q       <= lv_d;
            pix_q      <= pix_d;
            fd_q       <= fd_d;
        end
    end

    assign frame_valid = fv_q;
    assign line_valid  = lv_q;
    assign pixel_out   = pix_q;
    assign underrun    = underrun_q;
    assign frame_done  = fd_q;

endmodule
